// File: rtl/adder_sum_stage_if.sv
// Handshake and data bundle between the prefix stage, the sum stage and its consumer.
`ifndef LEN_DATA
`define LEN_DATA 63
`endif

interface adder_sum_stage_if #(
    parameter int TAG_W = 4
);
    localparam int N = `LEN_DATA + 1;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     generate_in;
    logic [N-1:0]     propogate_in;
    logic [N-1:0]     half_sum;
    logic             carry_in;
    logic [1:0]       size;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, generate_in, propogate_in, half_sum, carry_in, size, tag_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero, negative, tag_out
    );

    modport slave (
        input  in_valid, generate_in, propogate_in, half_sum, carry_in, size, tag_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero, negative, tag_out
    );
endinterface

// File: rtl/adder_sum_stage.sv
// Final sum/flag stage of the prefix adder: combinational carry resolution at the input,
// followed by a 2-entry result FIFO that decouples upstream from downstream.
`ifndef LEN_DATA
`define LEN_DATA 63
`endif

module adder_sum_stage #(
    parameter int TAG_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    adder_sum_stage_if.slave bus
);
    localparam int DATA_W = `LEN_DATA + 1;

    // Returns {carry_out, overflow, zero, negative, sum} for the selected operand width.
    function automatic logic [DATA_W+3:0] sum_flags(
        input logic [DATA_W-1:0] g,
        input logic [DATA_W-1:0] p,
        input logic [DATA_W-1:0] h,
        input logic              cin,
        input logic [1:0]        size
    );
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] s;
        logic              co;
        int                m;
        m = (8 << size) - 1;
        c = '0;
        mask = '0;
        c[0] = cin;
        for (int i = 1; i < DATA_W; i++) c[i] = g[i-1] | (p[i-1] & cin);
        for (int i = 0; i < DATA_W; i++) mask[i] = (i <= m);
        s  = (h ^ c) & mask;
        co = g[m] | (p[m] & cin);
        return {co, co ^ c[m], s == '0, s[m], s};
    endfunction

    logic                    vld_p0;
    logic [DATA_W+3:0]       res_p0;
    logic [1:0]              count_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic                    pop;
    logic [DATA_W-1:0]       sum_mem  [2];
    logic [3:0]              flag_mem [2];
    logic [TAG_W-1:0]        tag_mem  [2];

    // Stage p0: carries, sum and flags resolved combinationally on the accepted input
    assign bus.in_ready = (count_q < 2'd2);
    assign vld_p0       = bus.in_valid & bus.in_ready;
    assign res_p0       = sum_flags(bus.generate_in, bus.propogate_in, bus.half_sum,
                                    bus.carry_in, bus.size);
    assign pop          = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (vld_p0) wr_ptr_q <= ~wr_ptr_q;
            if (pop)    rd_ptr_q <= ~rd_ptr_q;
            case ({vld_p0, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage holds data only; validity is tracked entirely by count_q
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            sum_mem[wr_ptr_q]  <= res_p0[DATA_W-1:0];
            flag_mem[wr_ptr_q] <= res_p0[DATA_W+3:DATA_W];
            tag_mem[wr_ptr_q]  <= bus.tag_in;
        end
    end

    // Stage p1: head of FIFO presented, forced to zero while empty
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.sum       = bus.out_valid ? sum_mem[rd_ptr_q] : '0;
    assign bus.tag_out   = bus.out_valid ? tag_mem[rd_ptr_q] : '0;
    assign bus.carry_out = bus.out_valid & flag_mem[rd_ptr_q][3];
    assign bus.overflow  = bus.out_valid & flag_mem[rd_ptr_q][2];
    assign bus.zero      = bus.out_valid & flag_mem[rd_ptr_q][1];
    assign bus.negative  = bus.out_valid & flag_mem[rd_ptr_q][0];
endmodule
